// File: rtl/ysyx_22050243_idu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22050243_idu_ctrl
// Brief    : Registered valid/ready decode-control stage. Decodes opcode,
//            funct3 and funct12 into the control bundle, classifies illegal
//            and system instructions, and halts intake after an ebreak.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_22050243_idu_ctrl #(
   parameter int XLEN    = 64,
   parameter int CSR_EN  = 1,
   parameter int MRET_EN = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     inst,
   input  logic [XLEN-1:0] pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [31:0]     out_inst,
   output logic            alu_src,
   output logic            reg_w,
   output logic            mem_r,
   output logic            mem_w,
   output logic            branch,
   output logic            csr_r,
   output logic [2:0]      mem2reg,
   output logic [1:0]      pc_src_ctrl,
   output logic [2:0]      alu_op,
   output logic            illegal,
   output logic            is_ecall,
   output logic            is_ebreak,
   output logic            is_mret,
   output logic            is_fence,
   input  logic            flush,
   output logic            halt_req,
   input  logic            resume
);

   localparam logic [0:0] ST_RUN  = 1'b0;
   localparam logic [0:0] ST_HALT = 1'b1;

   logic [0:0] r_state;
   logic       w_accept;
   logic       w_load;

   logic       w_alu_src, w_reg_w, w_mem_r, w_mem_w, w_branch, w_csr_r;
   logic [2:0] w_mem2reg, w_alu_op;
   logic [1:0] w_pc_src;
   logic       w_bad, w_ecall, w_ebreak, w_mret, w_fence;

   assign in_ready = (r_state == ST_RUN) && (!out_valid || out_ready);
   assign w_accept = in_valid && in_ready;
   // A flush in the same cycle as an accept drops the incoming instruction
   assign w_load   = w_accept && !flush;
   assign halt_req = (r_state == ST_HALT);

   // Main decoder: opcode/funct3/funct12 to control bundle and classification
   always_comb begin
      w_alu_src = 1'b0;
      w_reg_w   = 1'b0;
      w_mem_r   = 1'b0;
      w_mem_w   = 1'b0;
      w_branch  = 1'b0;
      w_csr_r   = 1'b0;
      w_mem2reg = 3'b000;
      w_pc_src  = 2'b00;
      w_alu_op  = 3'b000;
      w_bad     = 1'b0;
      w_ecall   = 1'b0;
      w_ebreak  = 1'b0;
      w_mret    = 1'b0;
      w_fence   = 1'b0;
      // Opcodes with inst[1:0] != 2'b11 never match below and fall to default
      case (inst[6:0])
         7'b0110111: begin w_mem2reg = 3'b010; w_reg_w = 1'b1; end
         7'b0010111: begin w_mem2reg = 3'b100; w_reg_w = 1'b1; end
         7'b1101111: begin w_mem2reg = 3'b011; w_reg_w = 1'b1; w_pc_src = 2'b01; end
         7'b1100111: begin w_mem2reg = 3'b011; w_reg_w = 1'b1; w_pc_src = 2'b10; end
         7'b1100011: begin w_branch = 1'b1; w_alu_op = 3'b001; end
         7'b0000011: begin w_alu_src = 1'b1; w_mem2reg = 3'b001; w_reg_w = 1'b1; w_mem_r = 1'b1; end
         7'b0100011: begin w_alu_src = 1'b1; w_mem_w = 1'b1; end
         7'b0010011: begin w_alu_src = 1'b1; w_reg_w = 1'b1; w_alu_op = 3'b011; end
         7'b0110011: begin w_reg_w = 1'b1; w_alu_op = 3'b010; end
         7'b0011011: begin
            w_alu_src = 1'b1; w_reg_w = 1'b1; w_alu_op = 3'b111;
            w_bad     = (XLEN != 64);
         end
         7'b0111011: begin
            w_reg_w = 1'b1; w_alu_op = 3'b110;
            w_bad   = (XLEN != 64);
         end
         7'b0001111: w_fence = 1'b1;
         7'b1110011: begin
            if (inst[14:12] == 3'b000) begin
               if (inst[31:7] == 25'd0)
                  w_ecall = 1'b1;
               else if (inst[31:20] == 12'h001)
                  w_ebreak = 1'b1;
               else if ((inst[31:20] == 12'h302) && (MRET_EN != 0))
                  w_mret = 1'b1;
               else
                  w_bad = 1'b1;
            end else if (inst[14:12] == 3'b100) begin
               w_bad = 1'b1;
            end else if (CSR_EN != 0) begin
               w_csr_r = 1'b1; w_mem2reg = 3'b101; w_reg_w = 1'b1;
            end else begin
               w_bad = 1'b1;
            end
         end
         default: w_bad = 1'b1;
      endcase
      // Illegal instructions must not cause any architectural side effect
      if (w_bad) begin
         w_reg_w  = 1'b0;
         w_mem_r  = 1'b0;
         w_mem_w  = 1'b0;
         w_branch = 1'b0;
         w_csr_r  = 1'b0;
         w_pc_src = 2'b00;
      end
   end

   // One-entry output register toward EXU
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid   <= 1'b0;
         out_pc      <= '0;
         out_inst    <= '0;
         alu_src     <= 1'b0;
         reg_w       <= 1'b0;
         mem_r       <= 1'b0;
         mem_w       <= 1'b0;
         branch      <= 1'b0;
         csr_r       <= 1'b0;
         mem2reg     <= 3'b000;
         pc_src_ctrl <= 2'b00;
         alu_op      <= 3'b000;
         illegal     <= 1'b0;
         is_ecall    <= 1'b0;
         is_ebreak   <= 1'b0;
         is_mret     <= 1'b0;
         is_fence    <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
         illegal   <= 1'b0;
         is_ecall  <= 1'b0;
         is_ebreak <= 1'b0;
         is_mret   <= 1'b0;
         is_fence  <= 1'b0;
      end else if (w_load) begin
         out_valid   <= 1'b1;
         out_pc      <= pc;
         out_inst    <= inst;
         alu_src     <= w_alu_src;
         reg_w       <= w_reg_w;
         mem_r       <= w_mem_r;
         mem_w       <= w_mem_w;
         branch      <= w_branch;
         csr_r       <= w_csr_r;
         mem2reg     <= w_mem2reg;
         pc_src_ctrl <= w_pc_src;
         alu_op      <= w_alu_op;
         illegal     <= w_bad;
         is_ecall    <= w_ecall;
         is_ebreak   <= w_ebreak;
         is_mret     <= w_mret;
         is_fence    <= w_fence;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // Halt FSM: enter on accepted ebreak, leave only on resume
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= ST_RUN;
      else if ((r_state == ST_RUN) && w_load && w_ebreak)
         r_state <= ST_HALT;
      else if ((r_state == ST_HALT) && resume)
         r_state <= ST_RUN;
   end

endmodule
`default_nettype wire
